// File: rtl/data_mem_ctrl.sv
// M-stage data memory controller: byte-lane store merge, write-first load path,
// alignment/range error detection. Define DM_TRACE_EN to print a store/error trace.
module data_mem_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_op,
  input  logic        load_en,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic [1:0]  byte_off,
  output logic        addr_err
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_SW   = 2'd1;
  localparam logic [1:0] OP_SH   = 2'd2;
  localparam logic [1:0] OP_SB   = 2'd3;

  logic [IDX_W-1:0] index;
  logic             access;
  logic             misalign;
  logic             err;
  logic             we;
  logic             do_load;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [31:0]      merged_word;
  logic [1:0]       byte_off_reg;
  logic             addr_err_reg;

  assign index  = addr[IDX_W+1:2];
  assign access = (store_op != OP_NONE) || load_en;

  always_comb begin
    be       = 4'b0000;
    wlanes   = 32'h0;
    misalign = 1'b0;
    case (store_op)
      OP_SW: begin
        be       = 4'b1111;
        wlanes   = wdata;
        misalign = (addr[1:0] != 2'b00);
      end
      OP_SH: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata[15:0]}};
        misalign = addr[0];
      end
      OP_SB: begin
        be       = 4'b0001 << addr[1:0];
        wlanes   = {4{wdata[7:0]}};
      end
      default: begin
        be       = 4'b0000;
        wlanes   = 32'h0;
        misalign = 1'b0;
      end
    endcase
  end

  assign err     = misalign || (access && (addr >= ADDR_LIMIT));
  assign we      = en && (store_op != OP_NONE) && !err;
  assign do_load = en && load_en && !err;

  // One RAM per byte lane; the read mux forwards the lane being written so a
  // same-cycle load sees the merged post-write word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_merged;
      logic [7:0] rd_lane_reg;

      assign lane_merged = (we && be[gi]) ? wlanes[8*gi +: 8] : lane_mem[index];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int w = 0; w < DEPTH; w++) begin
            lane_mem[w] <= 8'h00;
          end
        end else if (we && be[gi]) begin
          lane_mem[index] <= wlanes[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_lane_reg <= 8'h00;
        end else if (en) begin
          if (err) begin
            rd_lane_reg <= 8'h00;
          end else if (load_en) begin
            rd_lane_reg <= lane_merged;
          end
        end
      end

      assign merged_word[8*gi +: 8] = lane_merged;
      assign rdata[8*gi +: 8]       = rd_lane_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_off_reg <= 2'b00;
      addr_err_reg <= 1'b0;
    end else if (en) begin
      addr_err_reg <= err;
      if (do_load) begin
        byte_off_reg <= addr[1:0];
      end
    end
  end

  assign byte_off = byte_off_reg;
  assign addr_err = addr_err_reg;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && en) begin
      if (we) begin
        $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_word);
      end else if (err) begin
        $display("@%h: addr_err %h", pc, addr);
      end
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{pc, merged_word};
`endif

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, word count of the data RAM (byte range 0 .. 4*DEPTH-1).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  stage enable; 0 = stall, no state change.
REQ-005 addr  input  32  byte address from the ALU (M stage).
REQ-006 wdata  input  32  store data, right-aligned (low byte/half holds the value for sb/sh).
REQ-007 store_op  input  2  0 none, 1 sw, 2 sh, 3 sb.
REQ-008 load_en  input  1  any load (lw/lh/lhu/lb/lbu) in M stage.
REQ-009 pc  input  32  PC of the M-stage instruction, used only for trace.
REQ-010 rdata  output  32  raw aligned word for the W-stage load extender.
REQ-011 byte_off  output  2  registered addr[1:0], consumed by the load extender with rdata.
REQ-012 addr_err  output  1  registered error flag for the W-stage instruction.

Function
REQ-013 Word index = addr[11:2] (low log2(DEPTH) bits above bit 1).
REQ-014 Store byte enables: sw -> 4'b1111; sh -> addr[1] ? 4'b1100 : 4'b0011; sb -> 4'b0001 << addr[1:0].
REQ-015 Store lane data: sh replicates wdata[15:0] to both halves; sb replicates wdata[7:0] to all four bytes; only enabled lanes are written.
REQ-016 Write occurs at the posedge where en=1, store_op!=0 and no error is detected; other bytes of the word are preserved.
REQ-017 Error: sw with addr[1:0]!=0, sh with addr[0]!=0, or any access (store_op!=0 or load_en) with addr >= 4*DEPTH.
REQ-018 On error, no RAM write occurs, and at the next posedge rdata <= 0 and addr_err <= 1.
REQ-019 Load latency one cycle: at posedge with en=1 and load_en=1 and no error, rdata <= RAM[index] and byte_off <= addr[1:0].
REQ-020 Load and store to the same word in the same cycle: rdata returns the merged post-write word (write-first).
REQ-021 With en=1 and load_en=0, rdata and byte_off hold their values; addr_err <= error status of the current cycle (0 if no access).
REQ-022 With en=0: no write, rdata, byte_off and addr_err hold.
REQ-023 Back-to-back store then load of the same address in consecutive cycles returns the stored data with no bypass logic needed (RAM already updated).

Reset
REQ-024 reset takes priority over en and all other inputs.
REQ-025 On a posedge with reset=1: every RAM word <= 0, rdata <= 0, byte_off <= 0, addr_err <= 0; no store is performed in that cycle.
REQ-026 Reset asserted mid-sequence discards any store presented in the same cycle; the first cycle after reset behaves as post-power-up.

Configuration
REQ-027 Macro DM_TRACE_EN: when defined, each performed store prints one simulation line "@<pc hex>: *<word-aligned byte addr hex> <= <full post-write word hex>"; each error prints "@<pc hex>: addr_err <addr hex>".
REQ-028 Without DM_TRACE_EN: no display statements are compiled; RTL function is identical.

Verification
REQ-029 reset 1 cycle; load addr 0x0 -> next cycle rdata=0x00000000, addr_err=0.
REQ-030 sw 0x12345678 to 0x10; sb 0xAB to 0x11; load 0x10 -> rdata=0x1234AB78, byte_off=0.
REQ-031 sh 0xBEEF to 0x22 (word 0x20 previously 0) -> load 0x20 gives rdata=0xBEEF0000; load 0x23 gives byte_off=3.
REQ-032 sw to 0x6 and sh to 0x5 -> no write (word 0x4 unchanged), addr_err=1 the following cycle; load 0x1000 (DEPTH=1024) -> rdata=0, addr_err=1.
REQ-033 en=0 with sw 0xFFFFFFFF to 0x30 -> word 0x30 unchanged, outputs hold; reset asserted together with sw 0x1 to 0x40 -> word 0x40 reads 0.
REQ-034 Same-cycle sw 0xCAFEF00D and load at 0x44 -> next cycle rdata=0xCAFEF00D.
